// File: rtl/nibble_serial_add_sub_ctrl.sv
// Wide add/subtract sequencer: one 4-bit add/sub slice time-multiplexed LS nibble first,
// with the inter-nibble carry held in a register; start/done handshake to the requester.
module nibble_serial_add_sub_ctrl #(
    parameter int unsigned NIBBLES = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [4*NIBBLES-1:0] a,
    input  logic [4*NIBBLES-1:0] b,
    input  logic                 mode,
    output logic                 busy,
    output logic                 done,
    output logic [4*NIBBLES-1:0] result,
    output logic                 cout,
    output logic                 overflow
);
    localparam int unsigned W  = 4 * NIBBLES;
    localparam int unsigned IW = $clog2(NIBBLES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [IW-1:0]  idx_q, idx_d;
    logic           carry_q, carry_d;
    logic [W-1:0]   a_q, a_d;
    logic [W-1:0]   b_q, b_d;
    logic           mode_q, mode_d;
    logic [W-1:0]   result_q, result_d;
    logic           cout_q, cout_d;
    logic           overflow_q, overflow_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;

    logic [3:0]     a_nib, b_nib;
    logic [4:0]     sum;
    logic [3:0]     low_sum;
    logic           last;

    // Shared 4-bit slice: B is inverted for subtract, carry-in comes from the carry register.
    always_comb begin
        a_nib   = a_q[{idx_q, 2'b00} +: 4];
        b_nib   = b_q[{idx_q, 2'b00} +: 4] ^ {4{mode_q}};
        sum     = {1'b0, a_nib} + {1'b0, b_nib} + {4'b0000, carry_q};
        low_sum = {1'b0, a_nib[2:0]} + {1'b0, b_nib[2:0]} + {3'b000, carry_q};
        last    = (idx_q == IW'(NIBBLES - 1));
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        carry_d    = carry_q;
        a_d        = a_q;
        b_d        = b_q;
        mode_d     = mode_q;
        result_d   = result_q;
        cout_d     = cout_q;
        overflow_d = overflow_q;
        busy_d     = 1'b0;
        done_d     = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d  = RUN;
                    a_d      = a;
                    b_d      = b;
                    mode_d   = mode;
                    idx_d    = '0;
                    carry_d  = mode;
                    result_d = '0;
                    busy_d   = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                result_d[{idx_q, 2'b00} +: 4] = sum[3:0];
                carry_d = sum[4];
                if (last) begin
                    state_d    = DONE;
                    cout_d     = sum[4];
                    overflow_d = low_sum[3] ^ sum[4];
                    done_d     = 1'b1;
                end else begin
                    idx_d  = idx_q + IW'(1);
                    busy_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            carry_q    <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
            mode_q     <= 1'b0;
            result_q   <= '0;
            cout_q     <= 1'b0;
            overflow_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            carry_q    <= carry_d;
            a_q        <= a_d;
            b_q        <= b_d;
            mode_q     <= mode_d;
            result_q   <= result_d;
            cout_q     <= cout_d;
            overflow_q <= overflow_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign result   = result_q;
    assign cout     = cout_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_nibble_serial_add_sub_ctrl.sv
// Scoreboard bench for nibble_serial_add_sub_ctrl (NIBBLES=4): directed operations push
// expected results; a monitor pops and checks them whenever done is seen.
module tb_nibble_serial_add_sub_ctrl;
    localparam int unsigned NIB = 4;
    localparam int unsigned W   = 4 * NIB;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a, b;
    logic         mode;
    logic         busy, done, cout, overflow;
    logic [W-1:0] result;

    typedef struct {
        logic [W-1:0] r;
        logic         c;
        logic         o;
        int           acc_edge;
    } exp_t;

    exp_t exp_q[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    bit   mon_en = 1'b0;

    nibble_serial_add_sub_ctrl #(.NIBBLES(NIB)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .mode(mode),
        .busy(busy), .done(done), .result(result), .cout(cout), .overflow(overflow)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
        end
    endfunction

    // Monitor: every done must match the oldest outstanding operation.
    always @(negedge clk) begin
        if (mon_en) begin
            if (done && busy) check("done_and_busy", 1, 0);
            if (done) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("result", result, e.r);
                    check("cout", W'(cout), W'(e.c));
                    check("overflow", W'(overflow), W'(e.o));
                    check("latency", W'(cyc - e.acc_edge), W'(NIB));
                end
            end
        end
    end

    // Issue start at a negedge; accepted at the following posedge.
    task automatic issue(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tm,
                         input logic [W-1:0] er, input logic ec, input logic eo);
        exp_t e;
        start = 1'b1; a = ta; b = tb_; mode = tm;
        e.r = er; e.c = ec; e.o = eo; e.acc_edge = cyc + 1;
        exp_q.push_back(e);
    endtask

    task automatic wait_done();
        bit seen = 1'b0;
        for (int i = 0; i < 3 * NIB + 4 && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        if (!seen) check("done_timeout", 0, 1);
    endtask

    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tm,
                          input logic [W-1:0] er, input logic ec, input logic eo);
        @(negedge clk);
        issue(ta, tb_, tm, er, ec, eo);
        @(negedge clk);
        start = 1'b0; a = '1; b = '1; mode = ~tm;
        check("busy_after_start", W'(busy), W'(1));
        wait_done();
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; a = '0; b = '0; mode = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy", W'(busy), 0);
        check("rst_done", W'(done), 0);
        check("rst_result", result, 0);
        check("rst_cout", W'(cout), 0);
        check("rst_ovf", W'(overflow), 0);
        rst = 1'b0;
        mon_en = 1'b1;

        run_op(16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0, 1'b0);
        run_op(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
        run_op(16'h0004, 16'h0006, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        run_op(16'h0005, 16'h0005, 1'b1, 16'h0000, 1'b1, 1'b0);
        run_op(16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1);

        // Start during RUN is ignored; start in DONE runs back-to-back.
        @(negedge clk);
        issue(16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        start = 1'b1; a = 16'hAAAA; b = 16'h5555; mode = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done();
        issue(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
        @(negedge clk);
        start = 1'b0;
        check("b2b_busy", W'(busy), W'(1));
        check("b2b_no_done", W'(done), 0);
        wait_done();

        // Reset mid-RUN at idx==2, after a result with cout=1.
        run_op(16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1);
        @(negedge clk);
        start = 1'b1; a = 16'h1111; b = 16'h2222; mode = 1'b0;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_busy", W'(busy), 0);
        check("midrst_done", W'(done), 0);
        check("midrst_result", result, 0);
        check("midrst_cout", W'(cout), 0);
        check("midrst_ovf", W'(overflow), 0);
        repeat (3 * NIB) @(negedge clk);

        check("scoreboard_empty", W'(exp_q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
